sync_filter: RTL and testbench
==============================

// Module: sync_filter
// PURPOSE
//  Multi-channel input conditioner for asynchronous or noisy single-bit signals
//  (buttons, strobes, status lines from other clock domains).
//  Each channel passes through a STAGES-deep flop synchronizer, then a glitch filter.
//  A change reaches d_out only after the synced value holds for FILTER_LEN consecutive cycles.
//  Registered one-cycle rise/fall pulses are emitted per channel. Sits at the clk-domain boundary.
// PARAMETERS
//  CHANNELS   4     number of independent 1-bit channels (>=1)
//  STAGES     2     synchronizer depth in flops (>=2; else elaboration $error)
//  FILTER_LEN 4     consecutive stable cycles needed to accept a change (>=1; else $error)
//  RESET_VAL  '0    CHANNELS-bit reset value for sync stages and d_out
// PORTS
//  clk     in   1         clock; all logic on posedge
//  arst    in   1         reset, synchronous, active-high
//  d_in    in   CHANNELS  asynchronous raw inputs
//  d_sync  out  CHANNELS  last synchronizer stage (unfiltered)
//  d_out   out  CHANNELS  filtered, debounced level
//  rise    out  CHANNELS  1-cycle pulse, cycle d_out[i] goes 0->1
//  fall    out  CHANNELS  1-cycle pulse, cycle d_out[i] goes 1->0
// BEHAVIOUR
//  Reset (arst high at posedge): all sync stages = RESET_VAL, d_out = RESET_VAL,
//   all counters = 0, rise = fall = 0. Pending counts discarded; reset never creates pulses.
//  Synchronizer: stage[0] <= d_in; stage[k] <= stage[k-1]; d_sync = stage[STAGES-1].
//   d_in held stable before edge 1 -> d_sync updated at edge STAGES.
//  Filter, per channel i, counter cnt[i], width $clog2(FILTER_LEN) (min 1):
//   - d_sync[i] == d_out[i]: cnt[i] <= 0.
//   - d_sync[i] != d_out[i] and cnt[i] <  FILTER_LEN-1: cnt[i] <= cnt[i]+1.
//   - d_sync[i] != d_out[i] and cnt[i] == FILTER_LEN-1: d_out[i] <= d_sync[i], cnt[i] <= 0.
//   - counter never wraps; it clears on any agreement cycle, so FILTER_LEN-1 is the max value.
//  Latency: d_in step (stable) -> d_out at edge STAGES+FILTER_LEN.
//   FILTER_LEN=1: d_out follows d_sync one cycle late.
//  Glitch: any d_sync excursion shorter than FILTER_LEN cycles leaves d_out and pulses unchanged.
//  Pulses: rise[i] <= ~d_out[i] & next_d_out[i]; fall[i] <= d_out[i] & ~next_d_out[i].
//   Both are registered and coincide with the d_out update cycle, high exactly one cycle.
//   rise[i] & fall[i] is never 1.
//  Channels fully independent; simultaneous events on different channels pulse in the same cycle.
//  Reset mid-count: counter and stages cleared, so a change must re-propagate the full
//   STAGES+FILTER_LEN edges after arst deasserts.
//  Every output is a flop; no combinational path from d_in.
// TESTING (CHANNELS=4, STAGES=2, FILTER_LEN=4, RESET_VAL=4'h0 unless noted)
//  1 arst high 3 cycles with d_in=4'hF -> d_sync=d_out=rise=fall=0 during reset;
//    after release d_sync=F at edge 2, d_out=F and rise=F at edge 6, rise=0 at edge 7.
//  2 d_in[0] high for 3 cycles then low -> d_sync[0] high 3 cycles, d_out[0]=0,
//    rise[0] never asserts, cnt[0] back to 0.
//  3 d_out=4'h4, d_in[2] 1->0 held -> d_out[2]=0 and fall[2]=1 at edge 6, one cycle only.
//  4 d_in[3] 0->1 held, arst pulsed 1 cycle at edge 4 -> d_out[3] stays 0, no pulse;
//    d_out[3]=1 and rise[3]=1 at edge 6 after arst release.
//  5 same edge: d_in[0] 0->1, d_in[1] 1->0 -> rise=4'h1 and fall=4'h2 in the same cycle (edge 6).
//  6 STAGES=3, FILTER_LEN=1, RESET_VAL=4'hA: after reset d_out=A, no pulses;
//    d_in step 0->F -> d_out=F at edge 4, rise=4'h5, fall=4'h0.

Source files
------------

// File: rtl/sync_filter.sv
`default_nettype none
// ============================================================================
//  Module      : sync_filter
//  Description : Per-channel flop synchronizer followed by a stability filter
//                with registered rise/fall pulses on each accepted change.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_filter #(
    parameter int                    CHANNELS   = 4,
    parameter int                    STAGES     = 2,
    parameter int                    FILTER_LEN = 4,
    parameter logic [CHANNELS-1:0]   RESET_VAL  = '0
) (
    input  logic                clk,
    input  logic                arst,
    input  logic [CHANNELS-1:0] d_in,
    output logic [CHANNELS-1:0] d_sync,
    output logic [CHANNELS-1:0] d_out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);

    localparam int c_cnt_w = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(FILTER_LEN - 1);

    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("sync_filter: STAGES must be >= 2");
        end
        if (FILTER_LEN < 1) begin : g_bad_filter_len
            $error("sync_filter: FILTER_LEN must be >= 1");
        end
        if (CHANNELS < 1) begin : g_bad_channels
            $error("sync_filter: CHANNELS must be >= 1");
        end
    endgenerate

    logic [CHANNELS-1:0] r_stage [STAGES];
    logic [CHANNELS-1:0] r_dout;
    logic [CHANNELS-1:0] r_rise;
    logic [CHANNELS-1:0] r_fall;

    always_ff @(posedge clk) begin
        if (arst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_stage[k] <= RESET_VAL;
            end
        end else begin
            r_stage[0] <= d_in;
            for (int k = 1; k < STAGES; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_channel
            logic [c_cnt_w-1:0] r_cnt;
            logic               w_mismatch;
            logic               w_accept;
            logic               w_next;

            assign w_mismatch = r_stage[STAGES-1][i] != r_dout[i];
            assign w_accept   = w_mismatch && (r_cnt == c_cnt_max);
            assign w_next     = w_accept ? r_stage[STAGES-1][i] : r_dout[i];

            // Any agreement cycle discards the partial count, so glitches never accumulate.
            always_ff @(posedge clk) begin
                if (arst) begin
                    r_cnt     <= '0;
                    r_dout[i] <= RESET_VAL[i];
                    r_rise[i] <= 1'b0;
                    r_fall[i] <= 1'b0;
                end else begin
                    if (!w_mismatch || w_accept) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    r_dout[i] <= w_next;
                    r_rise[i] <= ~r_dout[i] &  w_next;
                    r_fall[i] <=  r_dout[i] & ~w_next;
                end
            end
        end
    endgenerate

    assign d_sync = r_stage[STAGES-1];
    assign d_out  = r_dout;
    assign rise   = r_rise;
    assign fall   = r_fall;

endmodule
`default_nettype wire

// File: tb/tb_sync_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_filter
//  Description : Directed self-checking bench for sync_filter (two configs).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sync_filter;

    logic       clk = 1'b0;
    logic       arst_a, arst_b;
    logic [3:0] din_a, din_b;
    logic [3:0] dsync_a, dout_a, rise_a, fall_a;
    logic [3:0] dsync_b, dout_b, rise_b, fall_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sync_filter #(
        .CHANNELS(4), .STAGES(2), .FILTER_LEN(4), .RESET_VAL(4'h0)
    ) u_dut_a (
        .clk(clk), .arst(arst_a), .d_in(din_a),
        .d_sync(dsync_a), .d_out(dout_a), .rise(rise_a), .fall(fall_a)
    );

    sync_filter #(
        .CHANNELS(4), .STAGES(3), .FILTER_LEN(1), .RESET_VAL(4'hA)
    ) u_dut_b (
        .clk(clk), .arst(arst_b), .d_in(din_b),
        .d_sync(dsync_b), .d_out(dout_b), .rise(rise_b), .fall(fall_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [3:0] o, input logic [3:0] r,
                         input logic [3:0] f);
        check({tag, ".d_out"}, 32'(dout_a), 32'(o));
        check({tag, ".rise"},  32'(rise_a), 32'(r));
        check({tag, ".fall"},  32'(fall_a), 32'(f));
    endtask

    // Accepting a stable change on DUT A takes 6 edges; 8 leaves it settled.
    task automatic settle_a(input logic [3:0] v);
        din_a = v;
        repeat (8) tick();
    endtask

    initial begin
        int hi_cnt;
        arst_a = 1'b1;
        arst_b = 1'b1;
        din_a  = 4'hF;
        din_b  = 4'h0;
        #1;

        // 1: reset hold and first propagation
        for (int n = 0; n < 3; n++) begin
            tick();
            check("t1.rst.d_sync", 32'(dsync_a), 32'h0);
            chk_a("t1.rst", 4'h0, 4'h0, 4'h0);
        end
        arst_a = 1'b0;
        tick();
        check("t1.e1.d_sync", 32'(dsync_a), 32'h0);
        tick();
        check("t1.e2.d_sync", 32'(dsync_a), 32'hF);
        for (int e = 3; e <= 5; e++) begin
            tick();
            chk_a("t1.wait", 4'h0, 4'h0, 4'h0);
        end
        tick();
        chk_a("t1.e6", 4'hF, 4'hF, 4'h0);
        tick();
        chk_a("t1.e7", 4'hF, 4'h0, 4'h0);

        // 2: three-cycle glitch on channel 0 is rejected
        arst_a = 1'b1;
        din_a  = 4'h0;
        tick();
        arst_a = 1'b0;
        repeat (4) tick();
        din_a  = 4'h1;
        hi_cnt = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (n == 2) din_a = 4'h0;
            if (dsync_a[0]) hi_cnt++;
            check("t2.d_out0", 32'(dout_a[0]), 32'h0);
            check("t2.rise0",  32'(rise_a[0]), 32'h0);
        end
        check("t2.sync_hi_cycles", 32'(hi_cnt), 32'd3);
        // Counter must have cleared: a real step still needs the full 6 edges
        din_a = 4'h1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk_a("t2.step.wait", 4'h0, 4'h0, 4'h0);
        end
        tick();
        chk_a("t2.step.e6", 4'h1, 4'h1, 4'h0);

        // 3: falling edge on channel 2
        arst_a = 1'b1;
        din_a  = 4'h0;
        tick();
        arst_a = 1'b0;
        settle_a(4'h4);
        chk_a("t3.pre", 4'h4, 4'h0, 4'h0);
        din_a = 4'h0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk_a("t3.wait", 4'h4, 4'h0, 4'h0);
        end
        tick();
        chk_a("t3.e6", 4'h0, 4'h0, 4'h4);
        tick();
        chk_a("t3.e7", 4'h0, 4'h0, 4'h0);

        // 4: reset mid-count restarts propagation
        din_a = 4'h8;
        repeat (3) begin
            tick();
            chk_a("t4.pre", 4'h0, 4'h0, 4'h0);
        end
        arst_a = 1'b1;
        tick();
        check("t4.rst.d_sync", 32'(dsync_a), 32'h0);
        chk_a("t4.rst", 4'h0, 4'h0, 4'h0);
        arst_a = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk_a("t4.wait", 4'h0, 4'h0, 4'h0);
        end
        tick();
        chk_a("t4.e6", 4'h8, 4'h8, 4'h0);

        // 5: simultaneous rise and fall on different channels
        settle_a(4'h2);
        chk_a("t5.pre", 4'h2, 4'h0, 4'h0);
        din_a = 4'h1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk_a("t5.wait", 4'h2, 4'h0, 4'h0);
        end
        tick();
        chk_a("t5.e6", 4'h1, 4'h1, 4'h2);
        tick();
        chk_a("t5.e7", 4'h1, 4'h0, 4'h0);

        // 6: STAGES=3, FILTER_LEN=1, RESET_VAL=A
        repeat (2) begin
            tick();
            check("t6.rst.d_out", 32'(dout_b), 32'hA);
            check("t6.rst.rise",  32'(rise_b), 32'h0);
            check("t6.rst.fall",  32'(fall_b), 32'h0);
        end
        arst_b = 1'b0;
        din_b  = 4'hF;
        for (int e = 1; e <= 3; e++) begin
            tick();
            check("t6.wait.d_out", 32'(dout_b), 32'hA);
            check("t6.wait.rise",  32'(rise_b), 32'h0);
            check("t6.wait.fall",  32'(fall_b), 32'h0);
        end
        check("t6.e3.d_sync", 32'(dsync_b), 32'hF);
        tick();
        check("t6.e4.d_out", 32'(dout_b), 32'hF);
        check("t6.e4.rise",  32'(rise_b), 32'h5);
        check("t6.e4.fall",  32'(fall_b), 32'h0);
        tick();
        check("t6.e5.rise",  32'(rise_b), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
